// File: rtl/beep_sequencer_if.sv
// ============================================================================
// Module      : beep_sequencer_if
// Description : Control/status bundle between the alarm/chime logic and the
//               beep sequencer (triggers in, busy/done/tone outputs back).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beep_sequencer_if;
    logic       trig_hi;
    logic       trig_lo;
    logic [3:0] beeps;
    logic       cancel;
    logic       busy;
    logic       done;
    logic       clk_512;
    logic       clk_1k;
    logic       open512;
    logic       open1k;

    // Controller side: issues triggers, observes status and tone signals
    modport master (
        output trig_hi, trig_lo, beeps, cancel,
        input  busy, done, clk_512, clk_1k, open512, open1k
    );

    // Sequencer side
    modport slave (
        input  trig_hi, trig_lo, beeps, cancel,
        output busy, done, clk_512, clk_1k, open512, open1k
    );
endinterface

`default_nettype wire

// File: rtl/beep_sequencer.sv
// ============================================================================
// Module      : beep_sequencer
// Description : Free-running 1 kHz / ~512 Hz tone dividers plus a beep
//               sequencer (IDLE/ON/GAP) producing tone enables for Beeper.
//               Optional macro BEEP_ALT_EN: alternate the tone on each beep,
//               starting with the triggered tone.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beep_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BEEP_MS = 200,
    parameter int GAP_MS  = 200
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    beep_sequencer_if.slave    bus
);

    localparam int MS_CYC  = CLK_HZ / 1000;
    localparam int T1K     = CLK_HZ / 2000;
    localparam int T512    = CLK_HZ / 1024;
    localparam int ON_CYC  = BEEP_MS * MS_CYC;
    localparam int GAP_CYC = GAP_MS * MS_CYC;
    localparam int DUR_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int DW      = $clog2(DUR_MAX + 1);
    localparam int D1W     = $clog2(T1K + 1);
    localparam int D5W     = $clog2(T512 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state;
    logic [DW-1:0]  dur_cnt;
    logic [3:0]     remaining;
    logic           tone_hi;     // tone of the beep currently playing
    logic           busy;
    logic           done;
    logic           open512;
    logic           open1k;

    logic [D1W-1:0] div1k_cnt;
    logic [D5W-1:0] div512_cnt;
    logic           clk_1k_q;
    logic           clk_512_q;

    // 1 kHz divider: count 0..T1K-1, toggle and wrap at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div1k_cnt <= '0;
            clk_1k_q  <= 1'b0;
        end else if (div1k_cnt == D1W'(T1K - 1)) begin
            div1k_cnt <= '0;
            clk_1k_q  <= ~clk_1k_q;
        end else begin
            div1k_cnt <= div1k_cnt + 1'b1;
        end
    end

    // ~512 Hz divider: count 0..T512-1, toggle and wrap at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div512_cnt <= '0;
            clk_512_q  <= 1'b0;
        end else if (div512_cnt == D5W'(T512 - 1)) begin
            div512_cnt <= '0;
            clk_512_q  <= ~clk_512_q;
        end else begin
            div512_cnt <= div512_cnt + 1'b1;
        end
    end

    // Sequencer FSM with registered busy/done/open outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dur_cnt   <= '0;
            remaining <= 4'd0;
            tone_hi   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            open512   <= 1'b0;
            open1k    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // trig_hi has priority; cancel has no effect here
                    if (bus.trig_hi || bus.trig_lo) begin
                        tone_hi <= bus.trig_hi;
                        dur_cnt <= '0;
                        if (bus.beeps == 4'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ON;
                            remaining <= bus.beeps;
                            busy      <= 1'b1;
                            open1k    <= bus.trig_hi;
                            open512   <= ~bus.trig_hi;
                        end
                    end
                end

                ON: begin
                    if (bus.cancel) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        open1k  <= 1'b0;
                        open512 <= 1'b0;
                        dur_cnt <= '0;
                    end else if (dur_cnt == DW'(ON_CYC - 1)) begin
                        dur_cnt <= '0;
                        open1k  <= 1'b0;
                        open512 <= 1'b0;
                        if (remaining == 4'd1) begin
                            // last beep: no trailing gap
                            state     <= IDLE;
                            remaining <= 4'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= GAP;
                            remaining <= remaining - 4'd1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (bus.cancel) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dur_cnt <= '0;
                    end else if (dur_cnt == DW'(GAP_CYC - 1)) begin
                        state   <= ON;
                        dur_cnt <= '0;
`ifdef BEEP_ALT_EN
                        tone_hi <= ~tone_hi;
                        open1k  <= ~tone_hi;
                        open512 <= tone_hi;
`else
                        open1k  <= tone_hi;
                        open512 <= ~tone_hi;
`endif
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    open1k  <= 1'b0;
                    open512 <= 1'b0;
                    dur_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.open512 = open512;
    assign bus.open1k  = open1k;
    assign bus.clk_1k  = clk_1k_q;
    assign bus.clk_512 = clk_512_q;

endmodule

`default_nettype wire
